fmap_wr_arbiter: RTL and testbench
==================================

Name: fmap_wr_arbiter

Overview:
- Shares the single write port of the output feature-map buffer between N_REQ conv output lanes. The lanes are the valid_o/data producers of the systolic-array channel groups.
- Round-robin arbitration with burst locking: the owner keeps the port for up to BURST_LEN beats, so each lane's writes stay contiguous.
- Sits between the per-lane systolic outputs and the feature-map SRAM. It also exposes busy/owner status to the layer controller.

Parameters:
- N_REQ, 4, number of requesting lanes (2..8).
- DATA_W, 16, write data width.
- ADDR_W, 10, buffer address width.
- BURST_LEN, 4, maximum beats per grant (1 = re-arbitrate every beat).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: returns to IDLE and resets the pointer. Accepted beats still complete their memory write.
- req_valid  in  N_REQ  per-lane write request.
- req_addr  in  N_REQ*ADDR_W  per-lane address; lane i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  per-lane data; same packing as req_addr.
- req_ready  out  N_REQ  per-lane accept; combinational, one-hot or zero.
- mem_we  out  1  registered buffer write enable.
- mem_addr  out  ADDR_W  registered write address.
- mem_wdata  out  DATA_W  registered write data.
- busy  out  1  registered; 1 while in BURST state.
- owner_id  out  3  registered index of the current/last granted lane.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner_id=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Beat transfer: a beat on lane i occurs when req_valid[i] && req_ready[i] in the same cycle.
- Write latency: the beat appears on mem_we/mem_addr/mem_wdata on the next clk edge (exactly 1 cycle). mem_we=0 in any cycle with no beat.
- IDLE state:
  - winner = first lane with valid set, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner]=1 in the same cycle; all other ready bits are 0. If no lane is valid, ready=0.
  - On a beat: owner_id<=winner, beat_cnt<=1.
  - If BURST_LEN>1 -> go to BURST, busy<=1. Otherwise stay in IDLE and set rr_ptr<=(winner+1) mod N_REQ.
- BURST state:
  - req_ready[owner]=req-independent 1; all other lanes 0.
  - Each owner beat increments beat_cnt.
  - Exit to IDLE when the beat that makes beat_cnt==BURST_LEN occurs, or when owner valid=0 in a cycle (early release, no beat). On exit: rr_ptr<=(owner+1) mod N_REQ, busy<=0, beat_cnt<=0.
- No bubble: the cycle after exit is IDLE and arbitrates combinationally, so back-to-back bursts from different lanes have zero dead cycles.
- Fairness: with all lanes continuously valid, grants rotate 0,1,2,3,0,... with BURST_LEN beats each.
- Simultaneous clr and beat: the beat is still written to memory on the next edge. State and pointer take the clr values (IDLE, rr_ptr=0, beat_cnt=0, busy=0).
- Async reset mid-burst: all registers return to reset values immediately. A pending write is dropped (mem_we=0).
- Address/data pass through unmodified. The arbiter does no address generation and no overlap checking.
- owner_id is zero-extended when N_REQ<8.

Optional Feature:
- Macro ARB_LANE0_PRIO_EN.
- When defined: in IDLE, lane 0 wins whenever req_valid[0]=1, regardless of rr_ptr. Lane 0 is used for the bias/partial-sum restore path. BURST locking is unchanged, so lane 0 never pre-empts an active burst.
- When undefined: pure round-robin as above.

Decomposition:
- Shared package cnn_pkg holds:
  - constants FMAP_DATA_W=16, FMAP_ADDR_W=10, ARB_N_REQ=4, ARB_BURST_LEN=4;
  - localparam ID_W=3;
  - state enum encoding (IDLE=1'b0, BURST=1'b1), consistent with the other layer controllers.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector, ptr. Outputs: one-hot grant, index, any. It is instantiated once.

Test Plan:
- Reset then single lane: rst_n low, then lane 2 valid with addr 0x010..0x013, data 0xA0..0xA3 -> ready[2]=1 for 4 cycles; mem_we=1 with matching addr/data one cycle later; busy=1 for cycles 2-4; owner_id=2.
- All four lanes valid continuously for 16 beats -> grant order 0,0,0,0,1,1,1,1,2,...,3; no idle cycle between bursts; 16 consecutive mem_we pulses.
- Early release: lane 1 valid for 2 beats, then valid drops -> IDLE after the drop cycle; rr_ptr=2; next request from lanes 1 and 3 is granted to lane 3.
- clr mid-burst: clr asserted on lane 0's 2nd beat -> that beat is written (mem_we=1 next cycle); state=IDLE, rr_ptr=0; lane 0 re-granted from beat_cnt=0.
- Async reset mid-burst: rst_n low during lane 3 beat 3 -> mem_we, busy, owner_id =0 immediately; no write issued after release.
- ARB_LANE0_PRIO_EN build: lanes 0 and 2 valid in IDLE with rr_ptr=1 -> lane 0 granted. In the default build under the same stimulus, lane 2 is granted.

Source files
------------

// File: rtl/cnn_pkg.sv
// +-----------------------------------------------------------------------+
// | cnn_pkg : shared constants and state encoding for the layer datapath   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

   localparam int FMAP_DATA_W   = 16;
   localparam int FMAP_ADDR_W   = 10;
   localparam int ARB_N_REQ     = 4;
   localparam int ARB_BURST_LEN = 4;
   localparam int ID_W          = 3;

   // Same one-bit encoding as the other layer controllers.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +-----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first set bit from ptr_i   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] lane;

   // Scan offsets high to low so the lowest offset from ptr_i wins last.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      lane  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = (PW+1)'(ptr_i) + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         lane = sum[PW-1:0];
         if (req_i[lane]) begin
            gnt_o       = '0;
            gnt_o[lane] = 1'b1;
            idx_o       = lane;
            any_o       = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fmap_wr_arbiter.sv
// +-----------------------------------------------------------------------+
// | fmap_wr_arbiter : burst-locked round-robin share of the fmap write port|
// | Option macro: ARB_LANE0_PRIO_EN (lane 0 wins every IDLE arbitration)   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module fmap_wr_arbiter
   import cnn_pkg::*;
#(
   parameter int N_REQ     = ARB_N_REQ,
   parameter int DATA_W    = FMAP_DATA_W,
   parameter int ADDR_W    = FMAP_ADDR_W,
   parameter int BURST_LEN = ARB_BURST_LEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     busy,
   output logic [ID_W-1:0]          owner_id
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
   logic               busy_q, busy_d;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q;

   logic [N_REQ-1:0]   pick_gnt, win_gnt;
   logic [PW-1:0]      pick_idx, win_idx;
   logic               pick_any, win_any;
   logic               beat;
   logic [PW-1:0]      beat_lane;

   function automatic logic [PW-1:0] next_lane(input logic [PW-1:0] l);
      return (l == PW'(N_REQ - 1)) ? '0 : l + PW'(1);
   endfunction

   rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_rr_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

`ifdef ARB_LANE0_PRIO_EN
   // Bias/partial-sum restore path jumps the rotation, but only from IDLE.
   always_comb begin
      if (req_valid[0]) begin
         win_gnt = {{(N_REQ-1){1'b0}}, 1'b1};
         win_idx = '0;
         win_any = 1'b1;
      end else begin
         win_gnt = pick_gnt;
         win_idx = pick_idx;
         win_any = pick_any;
      end
   end
`else
   assign win_gnt = pick_gnt;
   assign win_idx = pick_idx;
   assign win_any = pick_any;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      busy_d     = busy_q;
      req_ready  = '0;
      beat       = 1'b0;
      beat_lane  = owner_q;
      case (state_q)
         IDLE: begin
            req_ready = win_gnt;
            if (win_any) begin
               beat       = 1'b1;
               beat_lane  = win_idx;
               owner_d    = win_idx;
               beat_cnt_d = CW'(1);
               if (BURST_LEN > 1) begin
                  state_d = BURST;
                  busy_d  = 1'b1;
               end else begin
                  rr_ptr_d = next_lane(win_idx);
               end
            end
         end
         BURST: begin
            req_ready[owner_q] = 1'b1;
            beat = req_valid[owner_q];
            if (beat) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
            // Either the final beat of the burst or an idle owner ends the lock.
            if (!beat || beat_cnt_q == CW'(BURST_LEN - 1)) begin
               state_d    = IDLE;
               rr_ptr_d   = next_lane(owner_q);
               busy_d     = 1'b0;
               beat_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (clr) begin
         state_d    = IDLE;
         rr_ptr_d   = '0;
         beat_cnt_d = '0;
         busy_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
      end
   end

   // Write stage is independent of clr so an accepted beat always lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q <= beat;
         if (beat) begin
            mem_addr_q  <= req_addr[int'(beat_lane)*ADDR_W +: ADDR_W];
            mem_wdata_q <= req_data[int'(beat_lane)*DATA_W +: DATA_W];
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign owner_id  = ID_W'(owner_q);

endmodule

`default_nettype wire

// File: tb/tb_fmap_wr_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_fmap_wr_arbiter : directed scenarios plus randomized model checks   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_fmap_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int BL = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              busy;
   logic [2:0]        owner_id;

   int errors = 0;
   int checks = 0;

   // Reference model: lock flag, owner, beats taken, rotation pointer.
   bit            m_locked;
   int            m_owner, m_cnt, m_ptr, m_oid;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   fmap_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .BURST_LEN (BL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .owner_id  (owner_id)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int l;
      r = '0;
      if (m_locked) begin
         r[m_owner] = 1'b1;
         return r;
      end
`ifdef ARB_LANE0_PRIO_EN
      if (req_valid[0]) begin
         r[0] = 1'b1;
         return r;
      end
`endif
      for (int k = 0; k < N; k++) begin
         l = (m_ptr + k) % N;
         if (req_valid[l]) begin
            r[l] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_oid = 0;
      m_we = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic model_tick();
      logic [N-1:0] r;
      int  lane;
      bit  bt;
      r    = exp_ready() & req_valid;
      bt   = (r != '0);
      lane = 0;
      for (int l = 0; l < N; l++) if (r[l]) lane = l;
      m_we = bt;
      if (bt) begin
         m_addr = req_addr[lane*AW +: AW];
         m_data = req_data[lane*DW +: DW];
      end
      if (!m_locked) begin
         if (bt) begin
            m_oid = lane;
            if (BL > 1) begin
               m_locked = 1; m_owner = lane; m_cnt = 1;
            end else begin
               m_ptr = (lane + 1) % N;
            end
         end
      end else begin
         if (bt) m_cnt++;
         if (!bt || m_cnt == BL) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
         end
      end
      if (clr) begin
         m_locked = 0; m_ptr = 0; m_cnt = 0;
      end
   endtask

   // Advance one clock: model follows the inputs the DUT sees at this edge.
   task automatic tick();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || owner_id !== 3'd0 || mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_regs: we=%b busy=%b owner=%0d addr=%h data=%h, required all zero",
                  mem_we, busy, owner_id, mem_addr, mem_wdata);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got=%b required=0000", req_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_lane();
      logic [N-1:0] er;
      for (int b = 0; b < 5; b++) begin
         req_valid = (b < 4) ? 4'b0100 : 4'b0000;
         req_addr  = '0;
         req_data  = '0;
         req_addr[2*AW +: AW] = AW'(16 + b);
         req_data[2*DW +: DW] = DW'(160 + b);
         er = (b < 4) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL single_ready b=%0d: got=%b required=%b", b, req_ready, er);
         end
         checks++;
         if (busy !== (b >= 1 && b <= 3)) begin
            errors++; $display("FAIL single_busy b=%0d: got=%b", b, busy);
         end
         checks++;
         if (mem_we !== (b >= 1)) begin
            errors++; $display("FAIL single_we b=%0d: got=%b", b, mem_we);
         end
         if (b >= 1) begin
            checks++;
            if (mem_addr !== AW'(15 + b) || mem_wdata !== DW'(159 + b) || owner_id !== 3'd2) begin
               errors++;
               $display("FAIL single_write b=%0d: addr=%h data=%h owner=%0d required addr=%h data=%h owner=2",
                        b, mem_addr, mem_wdata, owner_id, AW'(15 + b), DW'(159 + b));
            end
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
         errors++; $display("FAIL single_tail_we: got=%b required=0", mem_we);
      end
      tick();
   endtask

   task automatic test_all_lanes();
      logic [N-1:0]  er;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      pa = '0; pd = '0;
      clr = 1'b1; req_valid = '0;
      tick();
      clr = 1'b0;
      for (int b = 0; b <= 16; b++) begin
         req_valid = (b < 16) ? 4'b1111 : 4'b0000;
         for (int l = 0; l < N; l++) begin
            req_addr[l*AW +: AW] = AW'($urandom);
            req_data[l*DW +: DW] = DW'($urandom);
         end
         @(negedge clk);
         if (b < 16) begin
            er = 4'b0001 << (b / 4);
            checks++;
            if (req_ready !== er) begin
               errors++; $display("FAIL rr_order b=%0d: got=%b required=%b", b, req_ready, er);
            end
         end
         if (b >= 1) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== pa || mem_wdata !== pd) begin
               errors++;
               $display("FAIL rr_write b=%0d: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                        b, mem_we, mem_addr, mem_wdata, pa, pd);
            end
         end
         pa = req_addr[(b/4 % N)*AW +: AW];
         pd = req_data[(b/4 % N)*DW +: DW];
         tick();
      end
   endtask

   task automatic test_early_release();
      logic [N-1:0] vt [6] = '{4'b0010, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
      logic [N-1:0] rt [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
      bit           bt [6] = '{0, 1, 1, 0, 1, 0};
      bit           wt [6] = '{0, 1, 1, 0, 1, 0};
      for (int c = 0; c < 6; c++) begin
         req_valid = vt[c];
         @(negedge clk);
         checks++;
         if (req_ready !== rt[c] || busy !== bt[c] || mem_we !== wt[c]) begin
            errors++;
            $display("FAIL early_rel c=%0d: ready=%b busy=%b we=%b required ready=%b busy=%b we=%b",
                     c, req_ready, busy, mem_we, rt[c], bt[c], wt[c]);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (owner_id !== 3'd3) begin
         errors++; $display("FAIL early_owner: got=%0d required=3", owner_id);
      end
      tick();
   endtask

   task automatic test_clr_mid_burst();
      logic [DW-1:0] d2;
      logic [N-1:0]  er;
      d2 = '0;
      clr = 1'b1; req_valid = '0;
      tick();
      clr = 1'b0;
      for (int c = 0; c < 9; c++) begin
         req_valid = (c < 2) ? 4'b0001 : (c < 7) ? 4'b0011 : 4'b0000;
         req_data[0 +: DW] = DW'($urandom);
         clr = (c == 1);
         if (c == 1) d2 = req_data[0 +: DW];
         er = (c < 6) ? 4'b0001 : (c < 8) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL clr_ready c=%0d: got=%b required=%b", c, req_ready, er);
         end
         if (c == 2) begin
            checks++;
            if (mem_we !== 1'b1 || mem_wdata !== d2 || busy !== 1'b0) begin
               errors++;
               $display("FAIL clr_beat_kept: we=%b data=%h busy=%b required we=1 data=%h busy=0",
                        mem_we, mem_wdata, busy, d2);
            end
         end
         if (c >= 3 && c <= 5) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++; $display("FAIL clr_reburst c=%0d: busy=%b required=1", c, busy);
            end
         end
         tick();
      end
      clr = 1'b0;
   endtask

   task automatic test_async_reset();
      req_valid = 4'b1000;
      tick();
      tick();
      #2;
      checks++;
      if (mem_we !== 1'b1 || busy !== 1'b1 || owner_id !== 3'd3) begin
         errors++;
         $display("FAIL arst_pre: we=%b busy=%b owner=%0d required we=1 busy=1 owner=3", mem_we, busy, owner_id);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || owner_id !== 3'd0) begin
         errors++;
         $display("FAIL arst_now: we=%b busy=%b owner=%0d required all zero", mem_we, busy, owner_id);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_after c=%0d: we=%b busy=%b required 0", c, mem_we, busy);
         end
         tick();
      end
   endtask

   task automatic test_prio();
      logic [N-1:0] er;
`ifdef ARB_LANE0_PRIO_EN
      er = 4'b0001;
`else
      er = 4'b0100;
`endif
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      tick();
      req_valid = 4'b0101;
      @(negedge clk);
      checks++;
      if (req_ready !== er) begin
         errors++; $display("FAIL prio_grant: got=%b required=%b", req_ready, er);
      end
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      for (int c = 0; c < 400; c++) begin
         for (int l = 0; l < N; l++) begin
            req_valid[l]         = ($urandom_range(0, 3) != 0);
            req_addr[l*AW +: AW] = AW'($urandom);
            req_data[l*DW +: DW] = DW'($urandom);
         end
         clr = ($urandom_range(0, 31) == 0);
         er  = exp_ready();
         @(negedge clk);
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL rand_ready c=%0d: got=%b required=%b", c, req_ready, er);
         end
         checks++;
         if (mem_we !== m_we || busy !== m_locked || owner_id !== 3'(m_oid)) begin
            errors++;
            $display("FAIL rand_regs c=%0d: we=%b busy=%b owner=%0d required we=%b busy=%b owner=%0d",
                     c, mem_we, busy, owner_id, m_we, m_locked, m_oid);
         end
         if (m_we) begin
            checks++;
            if (mem_addr !== m_addr || mem_wdata !== m_data) begin
               errors++;
               $display("FAIL rand_write c=%0d: addr=%h data=%h required addr=%h data=%h",
                        c, mem_addr, mem_wdata, m_addr, m_data);
            end
         end
         tick();
      end
      clr = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_single_lane();
      test_all_lanes();
      test_early_release();
      test_clr_mid_burst();
      test_async_reset();
      test_prio();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
